// File: rtl/sysid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysid_pkg
// Description : Shared state encoding, expected sysid words and helper
//               function for the boot-time sysid checker.
// Revision    : 1.0
// ============================================================================
package sysid_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_rd_id = 3'd1;
    localparam state_t c_st_rd_ts = 3'd2;
    localparam state_t c_st_check = 3'd3;
    localparam state_t c_st_pass  = 3'd4;
    localparam state_t c_st_fail  = 3'd5;

    // Must track the values baked into the sysid slave generator.
    localparam logic [31:0] c_expected_id = 32'd0;
    localparam logic [31:0] c_expected_ts = 32'd1339225994;

    localparam int c_attempt_w = 4;
    localparam int c_timer_w   = 16;

    function automatic logic [c_attempt_w-1:0] sat_inc(input logic [c_attempt_w-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sysid_rd_timer.sv
`default_nettype none
// ============================================================================
// Module      : sysid_rd_timer
// Description : Loadable down-counter with expire flag for per-read timeout.
// Revision    : 1.0
// ============================================================================
module sysid_rd_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
// Module      : sysid_checker
// Description : Boot-time Avalon-MM reader of the sysid slave; holds the CPU
//               in reset until ID and timestamp match the expected build.
// Revision    : 1.0
// ============================================================================
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = c_expected_id,
    parameter logic [31:0] EXPECTED_TS    = c_expected_ts,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3,
    parameter int          AUTO_START     = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   avm_address,
    output logic                   avm_read,
    input  logic                   avm_waitrequest,
    input  logic [31:0]            avm_readdata,
    output logic                   busy,
    output logic                   pass,
    output logic                   fail,
    output logic                   cpu_reset_hold,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value,
    output logic [c_attempt_w-1:0] attempts
);

    // Loading N-1 makes the read time out on its Nth stalled cycle.
    localparam logic [c_timer_w-1:0]   c_timeout_load = c_timer_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_attempt_w-1:0] c_max_retries  = c_attempt_w'(MAX_RETRIES);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_avm_address;
    logic                   r_avm_read;
    logic                   r_busy;
    logic                   r_pass;
    logic                   r_fail;
    logic                   r_cpu_reset_hold;
    logic [31:0]            r_id_value;
    logic [31:0]            r_ts_value;
    logic [c_attempt_w-1:0] r_attempts;
    logic                   r_timed_out;

    logic w_in_read;
    logic w_accept;
    logic w_stall;
    logic w_timer_expired;
    logic w_timeout;
    logic w_timer_load;
    logic w_timer_dec;
    logic w_attempt_ok;
    logic w_enter_rd_id;
    logic w_fresh_start;

    assign w_in_read     = (r_state == c_st_rd_id) || (r_state == c_st_rd_ts);
    assign w_accept      = w_in_read && !avm_waitrequest;
    assign w_stall       = w_in_read && avm_waitrequest;
    assign w_timeout     = w_stall && w_timer_expired;
    // Reload whenever a fresh read is about to begin.
    assign w_timer_load  = !w_in_read || ((r_state == c_st_rd_id) && w_accept);
    assign w_timer_dec   = w_stall && !w_timer_expired;
    assign w_attempt_ok  = !r_timed_out && (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS);
    assign w_enter_rd_id = (w_state_nxt == c_st_rd_id) && (r_state != c_st_rd_id);
    assign w_fresh_start = w_enter_rd_id && (r_state != c_st_check);

    sysid_rd_timer #(
        .WIDTH (c_timer_w)
    ) u_rd_timer (
        .clk          (clock),
        .rst          (reset),
        .i_load       (w_timer_load),
        .i_load_value (c_timeout_load),
        .i_dec        (w_timer_dec),
        .o_expired    (w_timer_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if ((AUTO_START != 0) || start) w_state_nxt = c_st_rd_id;
            end
            c_st_rd_id: begin
                if (w_accept)       w_state_nxt = c_st_rd_ts;
                else if (w_timeout) w_state_nxt = c_st_check;
            end
            c_st_rd_ts: begin
                if (w_accept || w_timeout) w_state_nxt = c_st_check;
            end
            c_st_check: begin
                if (w_attempt_ok)                   w_state_nxt = c_st_pass;
                else if (r_attempts <= c_max_retries) w_state_nxt = c_st_rd_id;
                else                                w_state_nxt = c_st_fail;
            end
            c_st_pass, c_st_fail: begin
                if (start) w_state_nxt = c_st_rd_id;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= c_st_idle;
            r_avm_address    <= 1'b0;
            r_avm_read       <= 1'b0;
            r_busy           <= 1'b0;
            r_pass           <= 1'b0;
            r_fail           <= 1'b0;
            r_cpu_reset_hold <= 1'b1;
            r_id_value       <= '0;
            r_ts_value       <= '0;
            r_attempts       <= '0;
            r_timed_out      <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_avm_read       <= (w_state_nxt == c_st_rd_id) || (w_state_nxt == c_st_rd_ts);
            r_avm_address    <= (w_state_nxt == c_st_rd_ts);
            r_busy           <= (w_state_nxt == c_st_rd_id) || (w_state_nxt == c_st_rd_ts)
                             || (w_state_nxt == c_st_check);
            r_pass           <= (w_state_nxt == c_st_pass);
            r_fail           <= (w_state_nxt == c_st_fail);
            r_cpu_reset_hold <= (w_state_nxt != c_st_pass);

            if (w_enter_rd_id) begin
                r_attempts  <= w_fresh_start ? c_attempt_w'(1) : sat_inc(r_attempts);
                r_timed_out <= 1'b0;
            end else if (w_timeout) begin
                r_timed_out <= 1'b1;
            end

            if ((r_state == c_st_rd_id) && w_accept) r_id_value <= avm_readdata;
            if ((r_state == c_st_rd_ts) && w_accept) r_ts_value <= avm_readdata;
        end
    end

    assign avm_address    = r_avm_address;
    assign avm_read       = r_avm_read;
    assign busy           = r_busy;
    assign pass           = r_pass;
    assign fail           = r_fail;
    assign cpu_reset_hold = r_cpu_reset_hold;
    assign id_value       = r_id_value;
    assign ts_value       = r_ts_value;
    assign attempts       = r_attempts;

endmodule
`default_nettype wire

// File: tb/tb_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysid_checker
// Description : Self-checking bench for sysid_checker with three parameter
//               sets, a sysid slave model and a read-address scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_sysid_checker;

    localparam logic [31:0] c_id_good = 32'd0;
    localparam logic [31:0] c_ts_good = 32'd1339225994;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst, start, rd, addr, wreq, busy, pass, fail, hold;
    logic [2:0][31:0] rdata, idv, tsv;
    logic [2:0][3:0]  att;

    int          stall_n [3];
    bit          stuck   [3];
    logic [31:0] ts_resp [3];
    int          cnt     [3];

    int   n_checks = 0;
    int   n_fails  = 0;
    int   act      = 0;
    int   reads_seen = 0;
    logic exp_q[$];

    // 0: defaults, 1: short timeout without retries, 2: manual start
    sysid_checker u_dut_a (
        .clock(clk), .reset(rst[0]), .start(start[0]), .avm_address(addr[0]), .avm_read(rd[0]),
        .avm_waitrequest(wreq[0]), .avm_readdata(rdata[0]), .busy(busy[0]), .pass(pass[0]),
        .fail(fail[0]), .cpu_reset_hold(hold[0]), .id_value(idv[0]), .ts_value(tsv[0]),
        .attempts(att[0]));

    sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(0)) u_dut_b (
        .clock(clk), .reset(rst[1]), .start(start[1]), .avm_address(addr[1]), .avm_read(rd[1]),
        .avm_waitrequest(wreq[1]), .avm_readdata(rdata[1]), .busy(busy[1]), .pass(pass[1]),
        .fail(fail[1]), .cpu_reset_hold(hold[1]), .id_value(idv[1]), .ts_value(tsv[1]),
        .attempts(att[1]));

    sysid_checker #(.AUTO_START(0)) u_dut_c (
        .clock(clk), .reset(rst[2]), .start(start[2]), .avm_address(addr[2]), .avm_read(rd[2]),
        .avm_waitrequest(wreq[2]), .avm_readdata(rdata[2]), .busy(busy[2]), .pass(pass[2]),
        .fail(fail[2]), .cpu_reset_hold(hold[2]), .id_value(idv[2]), .ts_value(tsv[2]),
        .attempts(att[2]));

    // Slave model: each read stalls stall_n cycles (or forever if stuck).
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            wreq[i]  = rd[i] && (stuck[i] || (cnt[i] < stall_n[i]));
            rdata[i] = addr[i] ? ts_resp[i] : c_id_good;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i])                cnt[i] <= 0;
            else if (rd[i] && !wreq[i]) cnt[i] <= 0;
            else if (rd[i])            cnt[i] <= cnt[i] + 1;
        end
    end

    // Advance to the next mid-cycle point and score any accepted read.
    task automatic step();
        logic e;
        @(negedge clk);
        if (!rst[act] && rd[act] && !wreq[act]) begin
            n_checks++;
            reads_seen++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL scoreboard_read: unexpected read at address %0d, nothing expected", addr[act]);
            end else begin
                e = exp_q.pop_front();
                if (addr[act] !== e) begin
                    n_fails++;
                    $display("FAIL scoreboard_read: address %0d, expected %0d", addr[act], e);
                end
            end
        end
    endtask

    task automatic reset_dut(input int i);
        act = i;
        exp_q.delete();
        reads_seen = 0;
        rst[i] = 1'b1;
        step();
        step();
        rst[i] = 1'b0;
    endtask

    task automatic test_reset();
        act = 0;
        rst[0] = 1'b1;
        step();
        #1;
        n_checks++; if (rd[0] !== 1'b0)      begin n_fails++; $display("FAIL reset_read: got %b want 0", rd[0]); end
        n_checks++; if (addr[0] !== 1'b0)    begin n_fails++; $display("FAIL reset_addr: got %b want 0", addr[0]); end
        n_checks++; if (busy[0] !== 1'b0)    begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
        n_checks++; if (pass[0] !== 1'b0)    begin n_fails++; $display("FAIL reset_pass: got %b want 0", pass[0]); end
        n_checks++; if (fail[0] !== 1'b0)    begin n_fails++; $display("FAIL reset_fail: got %b want 0", fail[0]); end
        n_checks++; if (hold[0] !== 1'b1)    begin n_fails++; $display("FAIL reset_hold: got %b want 1", hold[0]); end
        n_checks++; if (idv[0] !== 32'd0)    begin n_fails++; $display("FAIL reset_id: got %0d want 0", idv[0]); end
        n_checks++; if (tsv[0] !== 32'd0)    begin n_fails++; $display("FAIL reset_ts: got %0d want 0", tsv[0]); end
        n_checks++; if (att[0] !== 4'd0)     begin n_fails++; $display("FAIL reset_attempts: got %0d want 0", att[0]); end
    endtask

    task automatic test_zero_wait();
        stall_n[0] = 0;
        ts_resp[0] = c_ts_good;
        reset_dut(0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        step();
        n_checks++; if (rd[0] !== 1'b1 || addr[0] !== 1'b0) begin n_fails++; $display("FAIL zw_cycle1: read=%b addr=%b want 1/0", rd[0], addr[0]); end
        step();
        n_checks++; if (rd[0] !== 1'b1 || addr[0] !== 1'b1) begin n_fails++; $display("FAIL zw_cycle2: read=%b addr=%b want 1/1", rd[0], addr[0]); end
        step();
        n_checks++; if (rd[0] !== 1'b0 || busy[0] !== 1'b1 || pass[0] !== 1'b0) begin n_fails++; $display("FAIL zw_check: read=%b busy=%b pass=%b want 0/1/0", rd[0], busy[0], pass[0]); end
        step();
        n_checks++; if (pass[0] !== 1'b1 || hold[0] !== 1'b0 || busy[0] !== 1'b0) begin n_fails++; $display("FAIL zw_pass: pass=%b hold=%b busy=%b want 1/0/0", pass[0], hold[0], busy[0]); end
        n_checks++; if (att[0] !== 4'd1) begin n_fails++; $display("FAIL zw_attempts: got %0d want 1", att[0]); end
        n_checks++; if (tsv[0] !== c_ts_good || idv[0] !== c_id_good) begin n_fails++; $display("FAIL zw_values: id=%0d ts=%0d", idv[0], tsv[0]); end
        step();
        n_checks++; if (reads_seen != 2 || exp_q.size() != 0) begin n_fails++; $display("FAIL zw_reads: seen %0d pending %0d want 2/0", reads_seen, exp_q.size()); end
    endtask

    task automatic test_bad_ts();
        stall_n[0] = 0;
        ts_resp[0] = c_ts_good + 32'd1;
        reset_dut(0);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(1'b0);
            exp_q.push_back(1'b1);
        end
        for (int c = 1; c <= 12; c++) step();
        n_checks++; if (fail[0] !== 1'b0 || busy[0] !== 1'b1) begin n_fails++; $display("FAIL bad_ts_cycle12: fail=%b busy=%b want 0/1", fail[0], busy[0]); end
        step();
        n_checks++; if (fail[0] !== 1'b1 || hold[0] !== 1'b1 || pass[0] !== 1'b0) begin n_fails++; $display("FAIL bad_ts_final: fail=%b hold=%b pass=%b want 1/1/0", fail[0], hold[0], pass[0]); end
        n_checks++; if (att[0] !== 4'd4) begin n_fails++; $display("FAIL bad_ts_attempts: got %0d want 4", att[0]); end
        n_checks++; if (tsv[0] !== 32'd1339225995) begin n_fails++; $display("FAIL bad_ts_value: got %0d want 1339225995", tsv[0]); end
        for (int c = 0; c < 5; c++) step();
        n_checks++; if (fail[0] !== 1'b1 || reads_seen != 8 || exp_q.size() != 0) begin n_fails++; $display("FAIL bad_ts_reads: fail=%b seen=%0d pending=%0d want 1/8/0", fail[0], reads_seen, exp_q.size()); end
        ts_resp[0] = c_ts_good;
    endtask

    task automatic test_wait_states();
        stall_n[0] = 3;
        reset_dut(0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int c = 1; c <= 8; c++) begin
            step();
            n_checks++;
            if (rd[0] !== 1'b1 || addr[0] !== (c > 4)) begin
                n_fails++;
                $display("FAIL ws_hold_c%0d: read=%b addr=%b want 1/%0d", c, rd[0], addr[0], (c > 4));
            end
        end
        step();
        n_checks++; if (pass[0] !== 1'b0 || busy[0] !== 1'b1) begin n_fails++; $display("FAIL ws_cycle9: pass=%b busy=%b want 0/1", pass[0], busy[0]); end
        step();
        n_checks++; if (pass[0] !== 1'b1 || hold[0] !== 1'b0) begin n_fails++; $display("FAIL ws_cycle10: pass=%b hold=%b want 1/0", pass[0], hold[0]); end
        n_checks++; if (reads_seen != 2 || exp_q.size() != 0) begin n_fails++; $display("FAIL ws_reads: seen %0d pending %0d want 2/0", reads_seen, exp_q.size()); end
    endtask

    task automatic test_timeout();
        stuck[1] = 1'b1;
        reset_dut(1);
        for (int c = 1; c <= 4; c++) begin
            step();
            n_checks++;
            if (rd[1] !== 1'b1 || addr[1] !== 1'b0) begin n_fails++; $display("FAIL to_read_c%0d: read=%b addr=%b want 1/0", c, rd[1], addr[1]); end
        end
        step();
        n_checks++; if (rd[1] !== 1'b0 || busy[1] !== 1'b1) begin n_fails++; $display("FAIL to_cycle5: read=%b busy=%b want 0/1", rd[1], busy[1]); end
        step();
        n_checks++; if (fail[1] !== 1'b1 || hold[1] !== 1'b1 || busy[1] !== 1'b0) begin n_fails++; $display("FAIL to_final: fail=%b hold=%b busy=%b want 1/1/0", fail[1], hold[1], busy[1]); end
        n_checks++; if (idv[1] !== 32'd0 || att[1] !== 4'd1) begin n_fails++; $display("FAIL to_values: id=%0d attempts=%0d want 0/1", idv[1], att[1]); end
        for (int c = 0; c < 4; c++) step();
        n_checks++; if (rd[1] !== 1'b0 || fail[1] !== 1'b1 || reads_seen != 0) begin n_fails++; $display("FAIL to_no_retry: read=%b fail=%b seen=%0d want 0/1/0", rd[1], fail[1], reads_seen); end
        rst[1] = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        stall_n[0] = 3;
        reset_dut(0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int c = 1; c <= 6; c++) step();
        n_checks++; if (rd[0] !== 1'b1 || addr[0] !== 1'b1) begin n_fails++; $display("FAIL rm_in_rdts: read=%b addr=%b want 1/1", rd[0], addr[0]); end
        #2 rst[0] = 1'b1;
        #1;
        n_checks++; if (rd[0] !== 1'b0 || addr[0] !== 1'b0 || busy[0] !== 1'b0) begin n_fails++; $display("FAIL rm_async: read=%b addr=%b busy=%b want 0/0/0", rd[0], addr[0], busy[0]); end
        n_checks++; if (hold[0] !== 1'b1 || idv[0] !== 32'd0 || att[0] !== 4'd0 || pass[0] !== 1'b0) begin n_fails++; $display("FAIL rm_values: hold=%b id=%0d att=%0d pass=%b", hold[0], idv[0], att[0], pass[0]); end
        stall_n[0] = 0;
        reset_dut(0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int c = 1; c <= 4; c++) step();
        n_checks++; if (pass[0] !== 1'b1 || hold[0] !== 1'b0 || reads_seen != 2) begin n_fails++; $display("FAIL rm_recheck: pass=%b hold=%b seen=%0d want 1/0/2", pass[0], hold[0], reads_seen); end
        rst[0] = 1'b1;
    endtask

    task automatic test_manual_start();
        stall_n[2] = 0;
        reset_dut(2);
        for (int c = 0; c < 5; c++) step();
        n_checks++; if (busy[2] !== 1'b0 || rd[2] !== 1'b0 || att[2] !== 4'd0 || hold[2] !== 1'b1) begin n_fails++; $display("FAIL ms_idle: busy=%b read=%b att=%0d hold=%b", busy[2], rd[2], att[2], hold[2]); end
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        // Held high across the busy and CHECK cycles; only the first sample counts.
        start[2] = 1'b1;
        for (int c = 1; c <= 4; c++) step();
        start[2] = 1'b0;
        n_checks++; if (pass[2] !== 1'b1 || att[2] !== 4'd1) begin n_fails++; $display("FAIL ms_pass: pass=%b att=%0d want 1/1", pass[2], att[2]); end
        step();
        n_checks++; if (pass[2] !== 1'b1 || busy[2] !== 1'b0 || reads_seen != 2) begin n_fails++; $display("FAIL ms_ignored: pass=%b busy=%b seen=%0d want 1/0/2", pass[2], busy[2], reads_seen); end
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        n_checks++; if (pass[2] !== 1'b0 || hold[2] !== 1'b1 || busy[2] !== 1'b1 || rd[2] !== 1'b1) begin n_fails++; $display("FAIL ms_restart: pass=%b hold=%b busy=%b read=%b want 0/1/1/1", pass[2], hold[2], busy[2], rd[2]); end
        n_checks++; if (att[2] !== 4'd1) begin n_fails++; $display("FAIL ms_restart_att: got %0d want 1", att[2]); end
        for (int c = 2; c <= 4; c++) step();
        n_checks++; if (pass[2] !== 1'b1 || hold[2] !== 1'b0 || reads_seen != 4 || exp_q.size() != 0) begin n_fails++; $display("FAIL ms_repass: pass=%b hold=%b seen=%0d pending=%0d", pass[2], hold[2], reads_seen, exp_q.size()); end
        rst[2] = 1'b1;
    endtask

    initial begin
        rst   = 3'b111;
        start = 3'b000;
        for (int i = 0; i < 3; i++) begin
            stall_n[i] = 0;
            stuck[i]   = 1'b0;
            ts_resp[i] = c_ts_good;
        end
        test_reset();
        test_zero_wait();
        test_bad_ts();
        test_wait_states();
        test_timeout();
        test_reset_mid_read();
        test_manual_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sysid_checker.md
# sysid_checker

Boot-time Avalon-MM master that reads the system ID slave (ID word at address 0, build timestamp at address 1) and compares both words against build-time expected values. It holds the CPU reset until the hardware/software build match is confirmed, so the PC-8001 core never runs against a mismatched FPGA image. It sits directly upstream of the sysid slave and drives its control_slave port through the interconnect.

## Interface

Parameters:
- EXPECTED_ID, 32'd0, expected word at address 0
- EXPECTED_TS, 32'd1339225994, expected timestamp at address 1
- TIMEOUT_CYCLES, 255, max cycles one read may stall on waitrequest (1..65535)
- MAX_RETRIES, 3, extra attempts after a failed one (0..15)
- AUTO_START, 1, start a check automatically after reset release

Ports:
- clock, in, 1, system clock; all logic on the rising edge
- reset, in, 1, asynchronous, active-high reset
- start, in, 1, one-cycle pulse; starts a check from IDLE, PASS or FAIL; ignored while busy
- avm_address, out, 1, word address to the sysid slave
- avm_read, out, 1, read strobe
- avm_waitrequest, in, 1, slave stall; 0 when tied off
- avm_readdata, in, 32, read data, valid in the cycle avm_read=1 and avm_waitrequest=0
- busy, out, 1, check in progress
- pass, out, 1, last check matched; sticky until the next start
- fail, out, 1, all attempts exhausted; sticky until the next start
- cpu_reset_hold, out, 1, 1 = hold the CPU in reset; 0 only in PASS
- id_value, out, 32, last captured address-0 word
- ts_value, out, 32, last captured address-1 word
- attempts, out, 4, attempts made in the current or last check

## Operation

- States: IDLE, RD_ID, RD_TS, CHECK, PASS, FAIL.
- IDLE: if AUTO_START=1, go to RD_ID on the first clock after reset release. Otherwise wait for start.
- RD_ID: drive avm_read=1 and avm_address=0, held stable until the accept cycle (waitrequest=0). On accept, capture id_value and go to RD_TS.
- RD_TS: same read with avm_address=1. On accept, capture ts_value and go to CHECK.
- Timeout counter: clears on entry to each read state and increments each stalled cycle. If it reaches TIMEOUT_CYCLES before accept, drop avm_read, mark the attempt failed and go to CHECK; captured values are left unchanged.
- CHECK (one cycle): the attempt passes if there was no timeout, id_value==EXPECTED_ID and ts_value==EXPECTED_TS.
  - Pass: go to PASS.
  - Fail with attempts ≤ MAX_RETRIES: go to RD_ID.
  - Otherwise: go to FAIL.
- attempts: cleared on start, incremented on each entry to RD_ID, saturating at 15.
- PASS: pass=1 and cpu_reset_hold=0.
- FAIL: fail=1 and cpu_reset_hold=1, held forever unless start.
- A start in PASS or FAIL clears pass/fail, sets cpu_reset_hold=1 and goes to RD_ID.
- busy=1 in RD_ID, RD_TS and CHECK.
- Reset mid-read drops avm_read asynchronously. No transaction completion is owed.

## Timing

- Reset values: avm_read=0, avm_address=0, busy=0, pass=0, fail=0, cpu_reset_hold=1, id_value=0, ts_value=0, attempts=0; state=IDLE.
- All outputs are registered; no combinational path from avm_readdata or avm_waitrequest to any output.
- Zero-wait slave with AUTO_START=1: read strobe cycles 1–2, CHECK cycle 3, pass=1 and cpu_reset_hold=0 visible from cycle 4 after reset release.
- Each waitrequest cycle adds one cycle.
- A timed-out read occupies exactly TIMEOUT_CYCLES cycles with avm_read=1.
- A start pulse in the same cycle as a CHECK decision is ignored.

## Structure

- sysid_pkg holds the state enum, the default EXPECTED_ID/EXPECTED_TS constants (shared with the sysid slave generator) and the attempt-counter width.
- One sub-module, sysid_rd_timer: a loadable down-counter with an expire flag, used for the per-read timeout.
- The FSM and capture registers live in the top level.

## Test plan

- Zero-wait slave returning 0 / 1339225994, AUTO_START=1: pass=1, cpu_reset_hold=0 at cycle 4; attempts=1; exactly 2 reads issued.
- Slave returns timestamp 1339225995, MAX_RETRIES=3: 4 attempts, 8 reads, then fail=1, cpu_reset_hold=1, ts_value=1339225995.
- waitrequest high for 3 cycles on each read: address and read held stable; pass at cycle 10.
- waitrequest stuck high, TIMEOUT_CYCLES=4, MAX_RETRIES=0: avm_read high 4 cycles, then fail=1, id_value=0.
- Reset asserted during RD_TS wait: avm_read=0 immediately, all outputs at reset values; a clean check passes after release.
- AUTO_START=0: idle until start; a start during busy is ignored; a start in PASS clears pass and reruns the check.
